// File: rtl/carry_accumulator.sv
// Pipelined carry-chain adder/accumulator: WIDTH-bit add split over SEGMENTS register stages,
// valid/ready handshake, internal accumulator. Define CARRY_ACCUM_SAT_EN to clamp on carry-out.
module carry_accumulator #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SEGMENTS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             sat,
    output logic [WIDTH-1:0] acc
);

    localparam int unsigned SegW = WIDTH / SEGMENTS;
    localparam int unsigned SumW = SegW + 1;
    localparam int unsigned Last = SEGMENTS - 1;

    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpAcc  = 2'b01;
    localparam logic [1:0] OpLoad = 2'b10;

    // Stage k register: w holds result slices 0..k and operand-A slices above k.
    logic [SEGMENTS-1:0]            valid_q, valid_d;
    logic [SEGMENTS-1:0][1:0]       op_q, op_d;
    logic [SEGMENTS-1:0][WIDTH-1:0] w_q, w_in, w_d;
    logic [SEGMENTS-1:0][WIDTH-1:0] y_q, y_d;
    logic [SEGMENTS-1:0]            c_q, c_in, c_d;
    logic [SEGMENTS-1:0][SegW:0]    seg_sum;
    logic [WIDTH-1:0]               acc_q;
    logic [1:0]                     op_dec;
    logic                           stall, acc_busy, accept, acc_wr, sat_d;
    logic                           unused_bits;

    assign stall    = valid_q[Last] && !out_ready;
    assign in_ready = !stall && !acc_busy;
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_busy = 1'b0;
        for (int k = 0; k < int'(SEGMENTS) - 1; k++) begin
            if (valid_q[k] && (op_q[k] != OpAdd)) begin
                acc_busy = 1'b1;
            end
        end
    end

    always_comb begin
        op_dec = OpAdd;
        unique case (mode)
            2'b01:   op_dec = OpAcc;
            2'b10:   op_dec = OpLoad;
            default: op_dec = OpAdd;
        endcase
    end

    // Stage inputs: stage 0 from the ports, stage k from stage k-1.
    always_comb begin
        valid_d = '0;
        op_d    = '0;
        w_in    = '0;
        y_d     = '0;
        c_in    = '0;
        valid_d[0] = accept;
        op_d[0]    = op_dec;
        w_in[0]    = a;
        c_in[0]    = (op_dec == OpLoad) ? 1'b0 : cin;
        unique case (op_dec)
            OpAcc:   y_d[0] = acc_q;
            OpLoad:  y_d[0] = '0;
            default: y_d[0] = b;
        endcase
        for (int k = 1; k < int'(SEGMENTS); k++) begin
            valid_d[k] = valid_q[k-1];
            op_d[k]    = op_q[k-1];
            w_in[k]    = w_q[k-1];
            y_d[k]     = y_q[k-1];
            c_in[k]    = c_q[k-1];
        end
    end

    always_comb begin
        seg_sum = '0;
        w_d     = w_in;
        c_d     = '0;
        sat_d   = 1'b0;
        for (int k = 0; k < int'(SEGMENTS); k++) begin
            seg_sum[k] = {1'b0, w_in[k][k*SegW +: SegW]} + {1'b0, y_d[k][k*SegW +: SegW]}
                       + SumW'(c_in[k]);
            w_d[k][k*SegW +: SegW] = seg_sum[k][SegW-1:0];
            c_d[k] = seg_sum[k][SegW];
        end
`ifdef CARRY_ACCUM_SAT_EN
        sat_d = c_d[Last] && (op_d[Last] != OpLoad);
        if (sat_d) begin
            w_d[Last] = '1;
        end
`endif
    end

    assign acc_wr = valid_d[Last] && (op_d[Last] != OpAdd);

    // A stall freezes every stage; data registers only load when a valid op moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            op_q    <= '0;
            w_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
        end else if (!stall) begin
            valid_q <= valid_d;
            for (int k = 0; k < int'(SEGMENTS); k++) begin
                if (valid_d[k]) begin
                    op_q[k] <= op_d[k];
                    w_q[k]  <= w_d[k];
                    y_q[k]  <= y_d[k];
                    c_q[k]  <= c_d[k];
                end
            end
            if (acc_wr) begin
                acc_q <= w_d[Last];
            end
        end
    end

`ifdef CARRY_ACCUM_SAT_EN
    logic sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (!stall && valid_d[Last]) begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    assign sat = 1'b0;
`endif

    // Operand-B slices already consumed and last-stage op/operand copies have no reader.
    assign unused_bits = ^{y_d, y_q[Last], op_q[Last], sat_d};

    assign out_valid = valid_q[Last];
    assign sum       = w_q[Last];
    assign cout      = c_q[Last];
    assign acc       = acc_q;

endmodule

// File: tb/tb_carry_accumulator.sv
// Bench for carry_accumulator (WIDTH=8, SEGMENTS=2): vector table plus directed corner sequences,
// results checked through an in-order scoreboard.
module tb_carry_accumulator;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;
`ifdef CARRY_ACCUM_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         sat;
        logic [W-1:0] acc;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         sat;
    logic [W-1:0] acc;

    int           errors = 0;
    int           checks = 0;
    vec_t         sb_q[$];
    logic [W-1:0] m_acc = '0;

    carry_accumulator #(
        .WIDTH   (W),
        .SEGMENTS(S)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .sat      (sat),
        .acc      (acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] md, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                input logic c, input logic [W-1:0] s, input logic co,
                                input logic st, input logic [W-1:0] ac);
        vec_t v;
        v.mode = md; v.a = aa; v.b = bb; v.cin = c;
        v.sum = s; v.cout = co; v.sat = st; v.acc = ac;
        return v;
    endfunction

    // Reference: full-width unsigned add, optional clamp, accumulator in program order.
    function automatic vec_t model(input logic [1:0] md, input logic [W-1:0] aa,
                                   input logic [W-1:0] bb, input logic c,
                                   input logic [W-1:0] acc_in);
        vec_t v;
        logic [W:0] full;
        v.mode = md; v.a = aa; v.b = bb; v.cin = c;
        if (md == 2'b10) begin
            v.sum = aa; v.cout = 1'b0; v.sat = 1'b0; v.acc = aa;
        end else begin
            if (md == 2'b01) full = {1'b0, acc_in} + {1'b0, aa} + (W+1)'(c);
            else             full = {1'b0, aa} + {1'b0, bb} + (W+1)'(c);
            v.sum  = full[W-1:0];
            v.cout = full[W];
            v.sat  = 1'b0;
            if (SatEn && full[W]) begin
                v.sum = '1;
                v.sat = 1'b1;
            end
            v.acc = (md == 2'b01) ? v.sum : acc_in;
        end
        return v;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1; mode = v.mode; a = v.a; b = v.b; cin = v.cin;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            sb_q.push_back(v);
            m_acc = v.acc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("sat", 32'(sat), 32'(e.sat));
                chk("acc", 32'(acc), 32'(e.acc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        vec_t v;

        tbl[0]  = mk(2'b00, 8'hF0, 8'h0F, 1'b1, SatEn ? 8'hFF : 8'h00, 1'b1, SatEn, 8'h00);
        tbl[1]  = mk(2'b00, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00);
        tbl[2]  = mk(2'b11, 8'h80, 8'h80, 1'b0, SatEn ? 8'hFF : 8'h00, 1'b1, SatEn, 8'h00);
        tbl[3]  = mk(2'b10, 8'h10, 8'hFF, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10);
        tbl[4]  = mk(2'b01, 8'h05, 8'hAA, 1'b0, 8'h15, 1'b0, 1'b0, 8'h15);
        tbl[5]  = mk(2'b01, 8'h0A, 8'h33, 1'b1, 8'h20, 1'b0, 1'b0, 8'h20);
        tbl[6]  = mk(2'b00, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 8'h20);
        tbl[7]  = mk(2'b10, 8'hF0, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 8'hF0);
        tbl[8]  = mk(2'b01, 8'h20, 8'h00, 1'b0, SatEn ? 8'hFF : 8'h10, 1'b1, SatEn,
                     SatEn ? 8'hFF : 8'h10);
        tbl[9]  = mk(2'b01, 8'h01, 8'h00, 1'b0, SatEn ? 8'hFF : 8'h11, SatEn, SatEn,
                     SatEn ? 8'hFF : 8'h11);
        tbl[10] = mk(2'b00, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, SatEn, SatEn ? 8'hFF : 8'h11);
        tbl[11] = mk(2'b10, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);

        // Reset state while reset is held
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Latency: result lands SEGMENTS edges after the accept (accept edge included)
        v = model(2'b00, 8'hF0, 8'h0F, 1'b1, m_acc);
        send(v);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        drain("drain_lat");

        // Vector table, offered back-to-back
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            send(tbl[i]);
        end
        drain("drain_table");

        // LOAD then ACC: ACC must wait for the LOAD to reach the output register
        @(posedge clk); #1;
        send(model(2'b10, 8'h10, 8'h00, 1'b0, m_acc));
        @(negedge clk);
        chk("acc_busy_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        v = model(2'b01, 8'h05, 8'h00, 1'b0, m_acc);
        chk("load_acc_model", 32'(v.sum), 32'h15);
        send(v);
        drain("drain_load_acc");

        // Stall: output held 3 cycles, then simultaneous consume and accept
        @(posedge clk); #1;
        out_ready = 1'b0;
        v = model(2'b00, 8'h3C, 8'h0F, 1'b1, m_acc);
        send(v);
        send(model(2'b00, 8'h11, 8'h22, 1'b0, m_acc));
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum", 32'(sum), 32'(v.sum));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(model(2'b00, 8'hC8, 8'h64, 1'b1, m_acc));
        drain("drain_stall");

        // Random ops with random downstream back-pressure
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            send(model(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                       1'($urandom_range(0, 1)), m_acc));
        end
        drain("drain_random");

        // Reset with two ops in flight
        @(posedge clk); #1;
        send(model(2'b10, 8'h5A, 8'h00, 1'b0, m_acc));
        drain("drain_pre_reset");
        @(posedge clk); #1;
        send(model(2'b00, 8'h12, 8'h34, 1'b0, m_acc));
        send(model(2'b00, 8'h56, 8'h78, 1'b1, m_acc));
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        m_acc = '0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_acc", 32'(acc), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_no_output", 32'(out_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
